// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler
// Round-robin merge of two stereo-frame producers into a shared frame FIFO,
// popped once per I2S word period by the encoder's latch strobe onto the
// 16-bit L/R sample registers. Underruns are flagged and counted.
//
// Optional build macro: I2S_FRAME_SCHEDULER_UNDERRUN_HOLD_EN
//   defined   -> on underrun the sample registers repeat the last frame
//   undefined -> on underrun the sample registers load silence (zeros)
module i2s_frame_scheduler #(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_latch,
    input  logic                  i_valid_a,
    input  logic [31:0]           i_data_a,
    output logic                  o_ready_a,
    input  logic                  i_valid_b,
    input  logic [31:0]           i_data_b,
    output logic                  o_ready_b,
    output logic [15:0]           o_data_l,
    output logic [15:0]           o_data_r,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_underrun,
    output logic [CNT_W-1:0]      o_underrun_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = (CNT_W)'(1);

    // Round-robin pointer names the port that won the most recent transfer
    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_t;

    rr_t                    r_rrPtr;
    logic [31:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wrPtr;
    logic [DEPTH_LOG2-1:0]  r_rdPtr;
    logic [DEPTH_LOG2:0]    r_level;
    logic [15:0]            r_dataL;
    logic [15:0]            r_dataR;
    logic                   r_underrun;
    logic [CNT_W-1:0]       r_underrunCount;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_canWrite;
    logic                   w_readyA;
    logic                   w_readyB;
    logic                   w_push;
    logic [31:0]            w_pushData;
    logic                   w_pop;
    logic                   w_underrun;
    logic [31:0]            w_head;

    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    assign w_canWrite = i_enable & ~w_full;
    assign w_push     = w_readyA | w_readyB;
    assign w_pushData = w_readyA ? i_data_a : i_data_b;
    assign w_pop      = i_enable & i_latch & ~w_empty;
    assign w_underrun = i_enable & i_latch & w_empty;
    assign w_head     = r_mem[r_rdPtr];

    // Grant: a lone valid wins outright; under contention the port not named by the pointer wins
    always_comb begin
        w_readyA = 1'b0;
        w_readyB = 1'b0;
        if (w_canWrite) begin
            if (i_valid_a && i_valid_b) begin
                if (r_rrPtr == RR_B) begin
                    w_readyA = 1'b1;
                end else begin
                    w_readyB = 1'b1;
                end
            end else begin
                w_readyA = i_valid_a;
                w_readyB = i_valid_b;
            end
        end
    end

    // Round-robin pointer follows the granted port, only on an accepted transfer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rrPtr <= RR_B;
        end else if (w_push) begin
            r_rrPtr <= w_readyA ? RR_A : RR_B;
        end
    end

    // Frame storage; pointers and level decide which entries are live
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_pushData;
        end
    end

    // FIFO pointers and occupancy; disable flushes the queue every cycle
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sample registers: head frame on pop, silence when disabled, underrun policy per build
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dataL <= '0;
            r_dataR <= '0;
        end else if (i_latch) begin
            if (!i_enable) begin
                r_dataL <= '0;
                r_dataR <= '0;
            end else if (!w_empty) begin
                r_dataL <= w_head[31:16];
                r_dataR <= w_head[15:0];
            end else begin
`ifdef I2S_FRAME_SCHEDULER_UNDERRUN_HOLD_EN
                r_dataL <= r_dataL;
                r_dataR <= r_dataR;
`else
                r_dataL <= '0;
                r_dataR <= '0;
`endif
            end
        end
    end

    // Underrun pulse and saturating count; nothing is flagged while disabled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_underrun      <= 1'b0;
            r_underrunCount <= '0;
        end else begin
            r_underrun <= w_underrun;
            if (w_underrun && (r_underrunCount != '1)) begin
                r_underrunCount <= r_underrunCount + CNT_ONE;
            end
        end
    end

    assign o_ready_a        = w_readyA;
    assign o_ready_b        = w_readyB;
    assign o_data_l         = r_dataL;
    assign o_data_r         = r_dataR;
    assign o_level          = r_level;
    assign o_underrun       = r_underrun;
    assign o_underrun_count = r_underrunCount;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// tb_i2s_frame_scheduler
// Directed and random stimulus against a queue-based reference model of the
// frame scheduler. Honors I2S_FRAME_SCHEDULER_UNDERRUN_HOLD_EN for the
// expected underrun output policy.
module tb_i2s_frame_scheduler;

    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int CNT_W      = 2;

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic                 latch;
    logic                 validA;
    logic [31:0]          dataA;
    logic                 readyA;
    logic                 validB;
    logic [31:0]          dataB;
    logic                 readyB;
    logic [15:0]          dataL;
    logic [15:0]          dataR;
    logic [DEPTH_LOG2:0]  level;
    logic                 underrun;
    logic [CNT_W-1:0]     underrunCount;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] modelQ [$];
    bit          modelLastB = 1'b1;
    logic [15:0] modelL = '0;
    logic [15:0] modelR = '0;
    bit          modelUnd = 1'b0;
    int          modelCnt = 0;

    i2s_frame_scheduler #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_enable(enable),
        .i_latch(latch),
        .i_valid_a(validA),
        .i_data_a(dataA),
        .o_ready_a(readyA),
        .i_valid_b(validB),
        .i_data_b(dataB),
        .o_ready_b(readyB),
        .o_data_l(dataL),
        .o_data_r(dataR),
        .o_level(level),
        .o_underrun(underrun),
        .o_underrun_count(underrunCount)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check grants, advance model, check registered outputs
    task automatic applyStimulus(input bit r, input bit en, input bit lat,
                                 input bit vA, input logic [31:0] dA,
                                 input bit vB, input logic [31:0] dB);
        bit expRdyA;
        bit expRdyB;
        bit room;
        logic [31:0] frame;
        rst    = r;
        enable = en;
        latch  = lat;
        validA = vA;
        dataA  = dA;
        validB = vB;
        dataB  = dB;
        #2;
        room    = en && (modelQ.size() < DEPTH);
        expRdyA = 1'b0;
        expRdyB = 1'b0;
        if (room) begin
            if (vA && vB) begin
                if (modelLastB) expRdyA = 1'b1;
                else            expRdyB = 1'b1;
            end else begin
                expRdyA = vA;
                expRdyB = vB;
            end
        end
        checkOutput("ready_a", 32'(readyA), 32'(expRdyA));
        checkOutput("ready_b", 32'(readyB), 32'(expRdyB));
        @(posedge clk);
        if (r) begin
            modelQ.delete();
            modelLastB = 1'b1;
            modelL     = '0;
            modelR     = '0;
            modelUnd   = 1'b0;
            modelCnt   = 0;
        end else if (!en) begin
            modelQ.delete();
            modelUnd = 1'b0;
            if (lat) begin
                modelL = '0;
                modelR = '0;
            end
        end else begin
            modelUnd = 1'b0;
            if (lat) begin
                if (modelQ.size() > 0) begin
                    frame  = modelQ.pop_front();
                    modelL = frame[31:16];
                    modelR = frame[15:0];
                end else begin
                    modelUnd = 1'b1;
                    if (modelCnt < (1 << CNT_W) - 1) modelCnt++;
`ifndef I2S_FRAME_SCHEDULER_UNDERRUN_HOLD_EN
                    modelL = '0;
                    modelR = '0;
`endif
                end
            end
            if (expRdyA) begin
                modelQ.push_back(dA);
                modelLastB = 1'b0;
            end else if (expRdyB) begin
                modelQ.push_back(dB);
                modelLastB = 1'b1;
            end
        end
        #1;
        checkOutput("data_l", 32'(dataL), 32'(modelL));
        checkOutput("data_r", 32'(dataR), 32'(modelR));
        checkOutput("level", 32'(level), 32'(modelQ.size()));
        checkOutput("underrun", 32'(underrun), 32'(modelUnd));
        checkOutput("underrun_count", 32'(underrunCount), 32'(modelCnt));
    endtask

    // Directed scenarios followed by a random soak
    initial begin
        rst = 1'b1; enable = 1'b0; latch = 1'b0;
        validA = 1'b0; dataA = '0; validB = 1'b0; dataB = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state
        applyStimulus(1, 1, 0, 0, 0, 0, 0);

        // Single push then pop
        applyStimulus(0, 1, 0, 1, 32'hF0F00F0F, 0, 0);
        checkOutput("single_level1", 32'(level), 32'd1);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("single_l", 32'(dataL), 32'hF0F0);
        checkOutput("single_r", 32'(dataR), 32'h0F0F);
        checkOutput("single_level0", 32'(level), 32'd0);

        // Contention: A, B, A, B then drain in that order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 1, 32'hAAAA0000 + 32'(i), 1, 32'hBBBB0000 + 32'(i));
        end
        checkOutput("contention_level", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 0, 0);
        end

        // Fill to full, pop with both valid held high, then accept resumes
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1, 0, 1, 32'h11110000 + 32'(i), 0, 0);
        end
        checkOutput("full_level", 32'(level), 32'(DEPTH));
        applyStimulus(0, 1, 1, 1, 32'h22220000, 1, 32'h33330000);
        checkOutput("full_pop_level", 32'(level), 32'(DEPTH - 1));
        applyStimulus(0, 1, 0, 1, 32'h22220001, 1, 32'h33330001);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 0, 0);
        end

        // Underrun after a known frame, then saturate the 2-bit counter
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 32'h12345678, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("underrun_pulse", 32'(underrun), 32'd1);
        checkOutput("underrun_cnt1", 32'(underrunCount), 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 0, 0);
        end
        checkOutput("underrun_sat", 32'(underrunCount), 32'd3);

        // Empty pop with same-cycle write: underrun, frame kept for next latch
        applyStimulus(0, 1, 1, 0, 0, 1, 32'hCAFEBABE);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);

        // Disable for one cycle with latch while frames are queued
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 1, 32'h44440000 + 32'(i), 0, 0);
        end
        applyStimulus(0, 0, 1, 1, 32'h55550000, 1, 32'h66660000);
        checkOutput("disable_level", 32'(level), 32'd0);
        checkOutput("disable_und", 32'(underrun), 32'd0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);

        // Reset during a push
        applyStimulus(0, 1, 0, 1, 32'h77770000, 0, 0);
        applyStimulus(1, 1, 1, 1, 32'h88880000, 1, 32'h99990000);
        checkOutput("rst_push_level", 32'(level), 32'd0);
        checkOutput("rst_push_cnt", 32'(underrunCount), 32'd0);

        // Random soak
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 4) < 3), $urandom(),
                          ($urandom_range(0, 4) < 3), $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Sequences stereo frames into the I2S encoder.
- Two producer ports (A, B) share one frame FIFO through round-robin arbitration.
- The encoder's latch strobe pops one frame per I2S word period onto the 16-bit L/R sample registers that feed the encoder's data inputs.
- Detects and counts underruns.

Parameters:
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 frames (legal 1..6)
CNT_W, 16, width of the saturating underrun counter

Ports:
i_clk  in  1  system clock, also the clock of the I2S encoder's bit-clock domain
i_rst  in  1  synchronous active-high reset
i_enable  in  1  scheduler enable; 0 = flush and mute
i_latch  in  1  single-cycle pop strobe from the encoder's latch output, synchronous to i_clk
i_valid_a  in  1  producer A frame valid
i_data_a  in  32  producer A frame, {L[15:0], R[15:0]}
o_ready_a  out  1  producer A frame accepted this cycle
i_valid_b  in  1  producer B frame valid
i_data_b  in  32  producer B frame, {L[15:0], R[15:0]}
o_ready_b  out  1  producer B frame accepted this cycle
o_data_l  out  16  left sample to encoder
o_data_r  out  16  right sample to encoder
o_level  out  DEPTH_LOG2+1  current FIFO occupancy
o_underrun  out  1  one-cycle pulse: pop requested while FIFO empty
o_underrun_count  out  CNT_W  saturating underrun count

Behaviour:
- Reset values (i_rst=1 at a clock edge): o_data_l = 0, o_data_r = 0, o_level = 0, o_underrun = 0, o_underrun_count = 0, FIFO empty, round-robin pointer = B. Reset wins over every other event in the same cycle, including a mid-transfer handshake.
- Handshake: valid/ready. A transfer occurs on a cycle where valid & ready = 1. o_ready_x is combinational from i_valid_*, the pointer, full and i_enable. Ready is never asserted when valid is low.
- Arbitration, write-accept condition: i_enable = 1 and level < depth.
  - Only one valid: that port gets ready.
  - Both valid: the port not named by the pointer gets ready.
  - Pointer updates to the granted port only on an accepted transfer.
  - Consequence: after reset A wins the first contention, then A and B alternate under continuous contention.
- Full: both readies are 0 when level == depth, even if i_latch pops in the same cycle. There is no write-through-pop when full.
- Pop, on i_latch = 1 and i_enable = 1:
  - If level > 0: the head frame is loaded into o_data_l/o_data_r at the next edge (1-cycle latency) and the head pointer advances.
  - If level == 0: an underrun. o_underrun pulses high for exactly the next cycle, and o_underrun_count increments, saturating at all-ones. Output handling is defined under Optional Feature.
- Empty with same-cycle write: a frame written in the same cycle as a pop on an empty FIFO is not bypassed. The pop is an underrun, and the frame becomes available for the next i_latch.
- Simultaneous push and pop with 0 < level < depth: level is unchanged.
- FIFO storage: circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo depth. o_level is a registered counter, exact at all times.
- i_enable = 0:
  - FIFO is flushed at each edge (level = 0, pointers = 0).
  - Readies are 0.
  - i_latch loads zeros into o_data_l/o_data_r.
  - No underrun is flagged or counted.
  - Counter and pointer hold.
- i_enable rising: normal operation resumes on the next cycle. No state beyond the FIFO and outputs is cleared.
- i_latch asserted on consecutive cycles: each cycle is an independent pop. This is legal though the encoder never does it.

Optional Feature:
Macro I2S_FRAME_SCHEDULER_UNDERRUN_HOLD_EN.
- Defined: on underrun, o_data_l/o_data_r hold their previous values (repeat the last frame).
- Undefined: on underrun, both load 16'h0000 (silence).
- Counting and the o_underrun pulse are identical in both builds.

Test Plan:
1. Reset then single push: A pushes 32'hF0F00F0F, then i_latch pulses → o_data_l = 16'hF0F0, o_data_r = 16'h0F0F one cycle after the latch, o_level returns 1 → 0.
2. Contention: A and B held valid with distinct data, 4 frames, no pops → accept order A, B, A, B; o_level = 4; subsequent pops emit frames in that order.
3. Full boundary (DEPTH_LOG2 = 3): 8 frames pushed → o_level = 8, both readies 0 while valid. i_latch pulsed with valid still high → no accept that cycle, o_level = 7, and an accept occurs on the next cycle.
4. Underrun: pop of 16'h1234/16'h5678, then i_latch on empty FIFO → o_underrun high for 1 cycle, count = 1. Outputs are 0/0, or 16'h1234/16'h5678 with I2S_FRAME_SCHEDULER_UNDERRUN_HOLD_EN. Repeated underruns with CNT_W = 2 → count saturates at 3.
5. Enable/reset mid-operation: 3 frames queued, i_enable = 0 for one cycle with i_latch → o_level = 0, outputs 0, no underrun pulse. Separately, i_rst asserted during a push → push lost, all outputs at reset values.
